// File: rtl/niosduino_pkg.sv
// Shared types and default cycle constants for the niosduino PLL supervisor.
// Latency: n/a (declarations only). Backpressure: n/a.
package niosduino_pkg;

   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABILIZE = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } pll_sup_state_t;

   // Defaults assume a 12 MHz reference clock.
   localparam int unsigned PLL_RST_CYCLES_DFLT      = 12;
   localparam int unsigned LOCK_TIMEOUT_CYCLES_DFLT = 12000;
   localparam int unsigned LOCK_STABLE_CYCLES_DFLT  = 1200;
   localparam int unsigned MAX_RETRIES_DFLT         = 3;
   localparam int unsigned CNT_W_DFLT               = 14;

endpackage

// File: rtl/niosduino_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
// Latency: 2 clk cycles. Backpressure: none.
module niosduino_sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/niosduino_pll_supervisor.sv
// Sequences PLL reset/lock on refclk and releases the core reset once lock is stable; bounded retries, fault and loss stats.
// Latency: pll_locked seen 2 cycles late, all outputs registered. Backpressure: none, soft_reset_req always accepted.
module niosduino_pll_supervisor
   import niosduino_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES      = PLL_RST_CYCLES_DFLT,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DFLT,
   parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DFLT,
   parameter int unsigned MAX_RETRIES         = MAX_RETRIES_DFLT,
   parameter int unsigned CNT_W               = CNT_W_DFLT
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       soft_reset_req,
   output logic       pll_rst,
   output logic       sys_reset_n,
   output logic       fault,
   output logic [1:0] retry_cnt,
   output logic [7:0] lock_loss_cnt,
   output logic [2:0] state_o
);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

   logic [1:0]       rst_pipe;
   logic             rst_sync_n;
   logic             locked_s;
   pll_sup_state_t   state;
   logic [CNT_W-1:0] timer;
   logic [1:0]       retry_inc;
   logic             attempt_fail;

   // Assert asynchronously, release two refclk edges after rst_n rises.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) rst_pipe <= 2'b00;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_sync_n = rst_pipe[1];

   niosduino_sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_sync_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   assign retry_inc    = retry_cnt + 2'd1;
   assign attempt_fail = !locked_s &&
                         ((state == ST_WAIT_LOCK && timer == TIMEOUT_LAST) || state == ST_STABILIZE);
   assign state_o      = state;

   always_ff @(posedge refclk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state         <= ST_RESET_PLL;
         timer         <= '0;
         pll_rst       <= 1'b1;
         sys_reset_n   <= 1'b0;
         fault         <= 1'b0;
         retry_cnt     <= 2'd0;
         lock_loss_cnt <= 8'd0;
      end else if (soft_reset_req) begin
         // Re-sequence from scratch; inside RESET_PLL only the pulse width restarts.
         state       <= ST_RESET_PLL;
         timer       <= '0;
         pll_rst     <= 1'b1;
         sys_reset_n <= 1'b0;
         fault       <= 1'b0;
         if (state != ST_RESET_PLL) retry_cnt <= 2'd0;
      end else if (attempt_fail) begin
         timer     <= '0;
         pll_rst   <= 1'b1;
         retry_cnt <= retry_inc;
         if (retry_inc == RETRY_MAX) begin
            state <= ST_FAULT;
            fault <= 1'b1;
         end else begin
            state <= ST_RESET_PLL;
         end
      end else begin
         case (state)
            ST_RESET_PLL: begin
               if (timer == RST_LAST) begin
                  state   <= ST_WAIT_LOCK;
                  timer   <= '0;
                  pll_rst <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state <= ST_STABILIZE;
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_STABILIZE: begin
               if (timer == STABLE_LAST) begin
                  state       <= ST_RUN;
                  timer       <= '0;
                  retry_cnt   <= 2'd0;
                  sys_reset_n <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_RUN: begin
               // Timer stays parked at zero here and in FAULT, so it can never wrap.
               if (!locked_s) begin
                  state       <= ST_RESET_PLL;
                  timer       <= '0;
                  pll_rst     <= 1'b1;
                  sys_reset_n <= 1'b0;
                  if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
               end
            end
            ST_FAULT: begin
               timer <= '0;
            end
            default: begin
               state       <= ST_RESET_PLL;
               timer       <= '0;
               pll_rst     <= 1'b1;
               sys_reset_n <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_niosduino_pll_supervisor.sv
// Directed bench for niosduino_pll_supervisor with short cycle parameters (4/20/8, two retries).
// Inputs change and outputs are sampled 1 time unit after each rising refclk edge.
module tb_niosduino_pll_supervisor;

   logic       refclk;
   logic       rst_n;
   logic       pll_locked;
   logic       soft_reset_req;
   logic       pll_rst;
   logic       sys_reset_n;
   logic       fault;
   logic [1:0] retry_cnt;
   logic [7:0] lock_loss_cnt;
   logic [2:0] state_o;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [2:0] S_RST = 3'd0, S_WAIT = 3'd1, S_STAB = 3'd2, S_RUN = 3'd3, S_FAULT = 3'd4;

   niosduino_pll_supervisor #(
      .PLL_RST_CYCLES      (4),
      .LOCK_TIMEOUT_CYCLES (20),
      .LOCK_STABLE_CYCLES  (8),
      .MAX_RETRIES         (2),
      .CNT_W               (14)
   ) dut (
      .refclk         (refclk),
      .rst_n          (rst_n),
      .pll_locked     (pll_locked),
      .soft_reset_req (soft_reset_req),
      .pll_rst        (pll_rst),
      .sys_reset_n    (sys_reset_n),
      .fault          (fault),
      .retry_cnt      (retry_cnt),
      .lock_loss_cnt  (lock_loss_cnt),
      .state_o        (state_o)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   // Safety invariants checked on every falling edge.
   always @(negedge refclk) begin
      n_cmp++;
      if (sys_reset_n === 1'b1 && state_o !== S_RUN) begin
         n_bad++;
         $display("FAIL inv_sysrst_only_in_run: sys_reset_n=1 with state=%0d, required RUN", state_o);
      end
      n_cmp++;
      if (pll_rst === 1'b1 && sys_reset_n === 1'b1) begin
         n_bad++;
         $display("FAIL inv_pllrst_vs_sysrst: pll_rst=1 and sys_reset_n=1 together, required not both");
      end
   end

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n          = 1'b0;
      pll_locked     = 1'b0;
      soft_reset_req = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
      int n = 0;
      while (state_o !== s && n < max) begin
         tick();
         n++;
      end
      ok = (state_o === s);
   endtask

   task automatic bring_up(output bit ok);
      bit a, b;
      wait_state(S_WAIT, 50, a);
      pll_locked = 1'b1;
      wait_state(S_RUN, 50, b);
      ok = a && b;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      pll_locked     = 1'b0;
      soft_reset_req = 1'b0;
      repeat (3) tick();
      n_cmp++; if (state_o !== S_RST) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
      n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
      n_cmp++; if (sys_reset_n !== 1'b0) begin n_bad++; $display("FAIL reset_sys_reset_n: got %b want 0", sys_reset_n); end
      n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_retry_cnt: got %0d want 0", retry_cnt); end
      n_cmp++; if (lock_loss_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_lock_loss_cnt: got %0d want 0", lock_loss_cnt); end
   endtask

   task automatic test_bringup();
      int n = 0;
      rst_n = 1'b1;
      // 2 edges of reset synchronization, then 4 edges of PLL reset pulse.
      while (pll_rst !== 1'b0 && n < 50) begin tick(); n++; end
      n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL bringup_pll_rst_width: fell after %0d edges want 6", n); end
      n_cmp++; if (state_o !== S_WAIT) begin n_bad++; $display("FAIL bringup_wait_state: got %0d want 1", state_o); end
      repeat (3) tick();
      pll_locked = 1'b1;
      // Count from the first edge that samples locked high: 2 sync + 8 stable.
      tick();
      n = 0;
      while (sys_reset_n !== 1'b1 && n < 50) begin tick(); n++; end
      n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL bringup_release_delay: got %0d cycles want 10", n); end
      n_cmp++; if (state_o !== S_RUN) begin n_bad++; $display("FAIL bringup_run_state: got %0d want 3", state_o); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL bringup_retry_cnt: got %0d want 0", retry_cnt); end
      n_cmp++; if (pll_rst !== 1'b0) begin n_bad++; $display("FAIL bringup_pll_rst_low: got %b want 0", pll_rst); end
   endtask

   task automatic test_glitch();
      bit ok;
      int n = 0;
      apply_reset();
      wait_state(S_WAIT, 50, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL glitch_reach_wait: state=%0d want 1", state_o); end
      pll_locked = 1'b1;
      repeat (5) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_state(S_RST, 20, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL glitch_attempt_fail: state=%0d want 0", state_o); end
      pll_locked = 1'b0;
      n_cmp++; if (retry_cnt !== 2'd1) begin n_bad++; $display("FAIL glitch_retry_cnt: got %0d want 1", retry_cnt); end
      n_cmp++; if (sys_reset_n !== 1'b0) begin n_bad++; $display("FAIL glitch_sys_reset_n: got %b want 0", sys_reset_n); end
      n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL glitch_pll_rst_reassert: got %b want 1", pll_rst); end
      while (pll_rst !== 1'b0 && n < 20) begin tick(); n++; end
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL glitch_pll_rst_width: got %0d want 4", n); end
      pll_locked = 1'b1;
      wait_state(S_RUN, 50, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL glitch_recover_run: state=%0d want 3", state_o); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL glitch_retry_cleared: got %0d want 0", retry_cnt); end
   endtask

   task automatic test_no_lock();
      bit ok;
      int n;
      apply_reset();
      wait_state(S_WAIT, 50, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL nolock_reach_wait1: state=%0d want 1", state_o); end
      n = 0;
      while (state_o === S_WAIT && n < 100) begin tick(); n++; end
      n_cmp++; if (n !== 20) begin n_bad++; $display("FAIL nolock_timeout1: got %0d cycles want 20", n); end
      n_cmp++; if (state_o !== S_RST) begin n_bad++; $display("FAIL nolock_retry_state: got %0d want 0", state_o); end
      n_cmp++; if (retry_cnt !== 2'd1) begin n_bad++; $display("FAIL nolock_retry1: got %0d want 1", retry_cnt); end
      wait_state(S_WAIT, 50, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL nolock_reach_wait2: state=%0d want 1", state_o); end
      n = 0;
      while (state_o === S_WAIT && n < 100) begin tick(); n++; end
      n_cmp++; if (n !== 20) begin n_bad++; $display("FAIL nolock_timeout2: got %0d cycles want 20", n); end
      n_cmp++; if (state_o !== S_FAULT) begin n_bad++; $display("FAIL nolock_fault_state: got %0d want 4", state_o); end
      n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL nolock_fault_flag: got %b want 1", fault); end
      n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL nolock_fault_pll_rst: got %b want 1", pll_rst); end
      n_cmp++; if (retry_cnt !== 2'd2) begin n_bad++; $display("FAIL nolock_retry2: got %0d want 2", retry_cnt); end
      repeat (10) tick();
      n_cmp++; if (state_o !== S_FAULT || fault !== 1'b1) begin n_bad++; $display("FAIL nolock_fault_sticky: state=%0d fault=%b want 4/1", state_o, fault); end
      soft_reset_req = 1'b1;
      tick();
      soft_reset_req = 1'b0;
      n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL nolock_soft_fault: got %b want 0", fault); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL nolock_soft_retry: got %0d want 0", retry_cnt); end
      n_cmp++; if (state_o !== S_RST) begin n_bad++; $display("FAIL nolock_soft_state: got %0d want 0", state_o); end
   endtask

   task automatic test_run_loss();
      bit ok;
      int n;
      bring_up(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL loss_initial_run: state=%0d want 3", state_o); end
      n_cmp++; if (lock_loss_cnt !== 8'd0) begin n_bad++; $display("FAIL loss_cnt_start: got %0d want 0", lock_loss_cnt); end
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b0;
         n = 0;
         while (sys_reset_n !== 1'b0 && n < 10) begin tick(); n++; end
         n_cmp++; if (n > 3 || n == 0) begin n_bad++; $display("FAIL loss_sysrst_delay iter %0d: got %0d cycles want 1..3", i, n); end
         if (i == 0) begin
            n_cmp++; if (lock_loss_cnt !== 8'd1) begin n_bad++; $display("FAIL loss_cnt_first: got %0d want 1", lock_loss_cnt); end
         end
         bring_up(ok);
         n_cmp++; if (!ok) begin n_bad++; $display("FAIL loss_rerun iter %0d: state=%0d want 3", i, state_o); end
      end
      n_cmp++; if (lock_loss_cnt !== 8'd255) begin n_bad++; $display("FAIL loss_cnt_saturate: got %0d want 255", lock_loss_cnt); end
   endtask

   task automatic test_simultaneous();
      bit ok;
      soft_reset_req = 1'b1;
      tick();
      soft_reset_req = 1'b0;
      pll_locked     = 1'b0;
      n_cmp++; if (state_o !== S_RST) begin n_bad++; $display("FAIL simul_soft_in_run_state: got %0d want 0", state_o); end
      n_cmp++; if (lock_loss_cnt !== 8'd255) begin n_bad++; $display("FAIL simul_soft_keeps_loss: got %0d want 255", lock_loss_cnt); end
      wait_state(S_WAIT, 50, ok);
      pll_locked = 1'b1;
      wait_state(S_STAB, 50, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL simul_reach_stab: state=%0d want 2", state_o); end
      pll_locked = 1'b0;
      tick();
      tick();
      // The synchronized drop and the soft request hit the FSM on the same edge.
      soft_reset_req = 1'b1;
      tick();
      soft_reset_req = 1'b0;
      n_cmp++; if (state_o !== S_RST) begin n_bad++; $display("FAIL simul_state: got %0d want 0", state_o); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL simul_retry_cnt: got %0d want 0", retry_cnt); end
   endtask

   task automatic test_async_reset();
      bit ok;
      wait_state(S_WAIT, 50, ok);
      pll_locked = 1'b1;
      wait_state(S_STAB, 50, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL arst_reach_stab: state=%0d want 2", state_o); end
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (state_o !== S_RST) begin n_bad++; $display("FAIL arst_state: got %0d want 0", state_o); end
      n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL arst_pll_rst: got %b want 1", pll_rst); end
      n_cmp++; if (sys_reset_n !== 1'b0) begin n_bad++; $display("FAIL arst_sys_reset_n: got %b want 0", sys_reset_n); end
      n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL arst_fault: got %b want 0", fault); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL arst_retry_cnt: got %0d want 0", retry_cnt); end
      n_cmp++; if (lock_loss_cnt !== 8'd0) begin n_bad++; $display("FAIL arst_lock_loss_cnt: got %0d want 0", lock_loss_cnt); end
      tick();
      pll_locked = 1'b0;
      rst_n      = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      rst_n          = 1'b0;
      pll_locked     = 1'b0;
      soft_reset_req = 1'b0;
      test_reset();
      test_bringup();
      test_glitch();
      test_no_lock();
      test_run_loss();
      test_simultaneous();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
